// File: rtl/alu_seq.sv
// Multi-cycle ALU for the execute stage: single-cycle logic/compare/shift ops plus iterative unsigned mul/div.
// Latency: 1 cycle for single-cycle ops, N+1 cycles (start edge to valid cycle) for mul/mulhu/divu/remu.
// Backpressure: busy is high while an iterative op runs; start is ignored (not queued) until busy drops.
module alu_seq #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   ALUControl,
  input  logic [N-1:0] SrcA,
  input  logic [N-1:0] SrcB,
  output logic [N-1:0] ALUResult,
  output logic         zero_flag,
  output logic         busy,
  output logic         valid
);

  localparam int SW = $clog2(N);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t         state;
  logic [N-1:0]   opa;      // multiplicand
  logic [N-1:0]   opb;      // multiplier (shifted right each step) or divisor
  logic [2*N-1:0] acc;      // product accumulator
  logic [N-1:0]   rem;      // partial remainder
  logic [N-1:0]   quo;      // dividend shifting out, quotient shifting in
  logic [SW-1:0]  cnt;
  logic           sel_hi;   // mulhu / remu: pick the "other" half of the result

  logic [N-1:0]   alu_comb;
  logic [SW-1:0]  shamt;

  logic [N:0]     mul_sum;
  logic [2*N-1:0] acc_next;

  logic [N:0]     div_shift;
  logic [N:0]     div_diff;
  logic           div_ge;
  logic [N-1:0]   rem_next;
  logic [N-1:0]   quo_next;
  logic [N-1:0]   mul_res;
  logic [N-1:0]   div_res;

  assign shamt = SrcB[SW-1:0];

  // Single-cycle result for the non-iterative opcodes; reserved codes give 0.
  always_comb begin
    alu_comb = '0;
    case (ALUControl)
      4'b0000: alu_comb = SrcA + SrcB;
      4'b0001: alu_comb = SrcA - SrcB;
      4'b0010: alu_comb = SrcA & SrcB;
      4'b0011: alu_comb = SrcA | SrcB;
      4'b0100: alu_comb = SrcA ^ SrcB;
      4'b0101: alu_comb = {{(N-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      4'b0110: alu_comb = {{(N-1){1'b0}}, (SrcA < SrcB)};
      4'b0111: alu_comb = SrcA << shamt;
      4'b1000: alu_comb = SrcA >> shamt;
      4'b1001: alu_comb = $signed(SrcA) >>> shamt;
      default: alu_comb = '0;
    endcase
  end

  // Shift-add step: add multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right; after N
  // steps acc holds the full 2N-bit product.
  assign mul_sum  = {1'b0, acc[2*N-1:N]} + {1'b0, (opb[0] ? opa : {N{1'b0}})};
  assign acc_next = {mul_sum, acc[N-1:1]};
  assign mul_res  = sel_hi ? acc_next[2*N-1:N] : acc_next[N-1:0];

  // Restoring division step. A zero divisor always "fits", which naturally
  // yields an all-ones quotient and a remainder equal to the dividend.
  assign div_shift = {rem, quo[N-1]};
  assign div_diff  = div_shift - {1'b0, opb};
  assign div_ge    = (div_shift >= {1'b0, opb});
  assign rem_next  = div_ge ? div_diff[N-1:0] : div_shift[N-1:0];
  assign quo_next  = {quo[N-2:0], div_ge};
  assign div_res   = sel_hi ? rem_next : quo_next;

  // Control FSM with registered result, zero flag, busy and valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ALUResult <= '0;
      zero_flag <= 1'b0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      opa       <= '0;
      opb       <= '0;
      rem       <= '0;
      quo       <= '0;
      sel_hi    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (start) begin
            case (ALUControl)
              4'b1010, 4'b1011: begin
                opa    <= SrcA;
                opb    <= SrcB;
                acc    <= '0;
                cnt    <= '0;
                sel_hi <= ALUControl[0];
                busy   <= 1'b1;
                state  <= MUL;
              end
              4'b1100, 4'b1101: begin
                opb    <= SrcB;
                quo    <= SrcA;
                rem    <= '0;
                cnt    <= '0;
                sel_hi <= ALUControl[0];
                busy   <= 1'b1;
                state  <= DIV;
              end
              default: begin
                ALUResult <= alu_comb;
                zero_flag <= (alu_comb == '0);
                valid     <= 1'b1;
                state     <= DONE;
              end
            endcase
          end
        end
        MUL: begin
          acc <= acc_next;
          opb <= opb >> 1;
          cnt <= cnt + SW'(1);
          if (cnt == SW'(N-1)) begin
            ALUResult <= mul_res;
            zero_flag <= (mul_res == '0);
            valid     <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end
        DIV: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt + SW'(1);
          if (cnt == SW'(N-1)) begin
            ALUResult <= div_res;
            zero_flag <= (div_res == '0);
            valid     <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed vector bench for alu_seq (N=32).
// Table of single/multi-cycle ops with result, zero flag, latency and busy-cycle checks,
// plus hand-written back-to-back, ignored-start and mid-op reset sequences.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  ALUControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [31:0] ALUResult;
  logic        zero_flag;
  logic        busy;
  logic        valid;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq #(.N(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ALUControl (ALUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ALUResult  (ALUResult),
    .zero_flag  (zero_flag),
    .busy       (busy),
    .valid      (valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op, wait (bounded) for valid, report result and timing.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic z, output int lat,
                       output int busy_cnt, output logic vld_after);
    @(negedge clk);
    start = 1'b1; ALUControl = op; SrcA = a; SrcB = b;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (!valid && lat < 100) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    res = ALUResult;
    z   = zero_flag;
    @(negedge clk);
    vld_after = valid;
  endtask

  initial begin
    logic [31:0] res;
    logic        z;
    int          lat;
    int          bc;
    logic        va;
    int          nv;
    logic [31:0] got;

    vecs[0]  = '{4'h0, 32'd5,         32'd7,         32'd12,        1};
    vecs[1]  = '{4'h1, 32'd9,         32'd9,         32'd0,         1};
    vecs[2]  = '{4'h1, 32'd0,         32'd1,         32'hFFFFFFFF,  1};
    vecs[3]  = '{4'h0, 32'hFFFFFFFF,  32'd1,         32'd0,         1};
    vecs[4]  = '{4'h2, 32'hF0F0F0F0,  32'hFF00FF00,  32'hF000F000,  1};
    vecs[5]  = '{4'h3, 32'hF0F0F0F0,  32'h0F0F0000,  32'hFFFFF0F0,  1};
    vecs[6]  = '{4'h4, 32'hFFFF0000,  32'h0F0F0F0F,  32'hF0F00F0F,  1};
    vecs[7]  = '{4'h5, 32'hFFFFFFFF,  32'd1,         32'd1,         1};
    vecs[8]  = '{4'h6, 32'hFFFFFFFF,  32'd1,         32'd0,         1};
    vecs[9]  = '{4'h7, 32'd1,         32'h25,        32'h20,        1};
    vecs[10] = '{4'h8, 32'h80000000,  32'd4,         32'h08000000,  1};
    vecs[11] = '{4'h9, 32'h80000000,  32'h24,        32'hF8000000,  1};
    vecs[12] = '{4'hE, 32'd5,         32'd7,         32'd0,         1};
    vecs[13] = '{4'hF, 32'hFFFFFFFF,  32'd3,         32'd0,         1};
    vecs[14] = '{4'hA, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001,  33};
    vecs[15] = '{4'hB, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  33};
    vecs[16] = '{4'hA, 32'h00010000,  32'h00010000,  32'd0,         33};
    vecs[17] = '{4'hB, 32'h00010000,  32'h00010000,  32'd1,         33};
    vecs[18] = '{4'hC, 32'd100,       32'd7,         32'd14,        33};
    vecs[19] = '{4'hD, 32'd100,       32'd7,         32'd2,         33};
    vecs[20] = '{4'hC, 32'd100,       32'd0,         32'hFFFFFFFF,  33};
    vecs[21] = '{4'hD, 32'd100,       32'd0,         32'd100,       33};
    vecs[22] = '{4'hC, 32'd7,         32'd100,       32'd0,         33};
    vecs[23] = '{4'hD, 32'hFFFFFFFF,  32'd10,        32'd5,         33};

    reset = 1'b1; start = 1'b0; ALUControl = 4'h0; SrcA = '0; SrcB = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset ALUResult", ALUResult, 32'd0);
    chk("reset zero_flag", {31'd0, zero_flag}, 32'd0);
    chk("reset busy",      {31'd0, busy},      32'd0);
    chk("reset valid",     {31'd0, valid},     32'd0);

    // Table-driven vectors.
    for (int i = 0; i < 24; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, z, lat, bc, va);
      chk($sformatf("vec%0d result", i),    res, vecs[i].exp);
      chk($sformatf("vec%0d zero_flag", i), {31'd0, z}, {31'd0, (vecs[i].exp == 32'd0)});
      chk($sformatf("vec%0d latency", i),   lat, vecs[i].lat);
      chk($sformatf("vec%0d busy cycles", i), bc, (vecs[i].lat == 33) ? 32 : 0);
      chk($sformatf("vec%0d valid pulse", i), {31'd0, va}, 32'd0);
    end

    // Back-to-back: sub issued in the DONE cycle of an add.
    @(negedge clk);
    start = 1'b1; ALUControl = 4'h0; SrcA = 32'd5; SrcB = 32'd7;
    @(negedge clk);
    chk("b2b add valid",  {31'd0, valid}, 32'd1);
    chk("b2b add result", ALUResult, 32'd12);
    chk("b2b add zero",   {31'd0, zero_flag}, 32'd0);
    start = 1'b1; ALUControl = 4'h1; SrcA = 32'd9; SrcB = 32'd9;
    @(negedge clk);
    start = 1'b0;
    chk("b2b sub valid",  {31'd0, valid}, 32'd1);
    chk("b2b sub result", ALUResult, 32'd0);
    chk("b2b sub zero",   {31'd0, zero_flag}, 32'd1);

    // Start pulses and operand churn during divu 100/7 must be ignored.
    @(negedge clk);
    start = 1'b1; ALUControl = 4'hC; SrcA = 32'd100; SrcB = 32'd7;
    nv = 0;
    got = 32'd0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (c < 20) begin
        start = 1'b1; ALUControl = 4'h0; SrcA = 32'd1000 + c; SrcB = 32'd1;
      end else begin
        start = 1'b0;
      end
      if (valid) begin
        nv++;
        got = ALUResult;
      end
    end
    chk("ignore-start valid count", nv, 32'd1);
    chk("ignore-start result",      got, 32'd14);

    // Reset ten cycles into mulhu aborts the operation.
    @(negedge clk);
    start = 1'b1; ALUControl = 4'hB; SrcA = 32'hFFFFFFFF; SrcB = 32'hFFFFFFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre-reset busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort busy",      {31'd0, busy},      32'd0);
    chk("abort ALUResult", ALUResult,          32'd0);
    chk("abort zero_flag", {31'd0, zero_flag}, 32'd0);
    nv = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (valid) nv++;
    end
    chk("abort no valid", nv, 32'd0);
    do_op(4'h0, 32'd3, 32'd4, res, z, lat, bc, va);
    chk("post-reset add result",  res, 32'd7);
    chk("post-reset add latency", lat, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
